// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// data_mem_responder
// Word-addressed stallable data memory: one request at a time, wait states,
// registered response with error flag for misaligned/out-of-range addresses.
// Revision: 1.0
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int         c_DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [31:0]           r_mem [c_DEPTH];
  logic                  w_accept;
  logic                  w_rsp_done;
  logic                  w_addr_err;
  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_idx;

  assign w_idx      = r_addr[DEPTH_LOG2+1:2];
  assign w_addr_err = (r_addr[1:0] != 2'b00) | (|r_addr[31:DEPTH_LOG2+2]);
  assign w_accept   = (r_state == S_IDLE) & req_valid;
  assign w_rsp_done = (r_state == S_RESP) & rsp_ready;
  assign w_mem_we   = (r_state == S_ACCESS) & r_we & ~w_addr_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          w_next = (c_WAIT_INIT == 4'd0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: w_next = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= c_WAIT_INIT;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Response fields are loaded once in ACCESS and held until the handshake.
      if (r_state == S_ACCESS) begin
        r_err   <= w_addr_err;
        r_rdata <= (w_addr_err | r_we) ? 32'd0 : r_mem[w_idx];
      end else if (w_rsp_done) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b0;
      end
    end
  end

  // Array has no reset: contents survive a reset that follows a completed store.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// Testbench for data_mem_responder: directed vectors on a WAIT_CYCLES=2
// instance (a_*) and a WAIT_CYCLES=0 instance (b_*).
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic        a_req_valid = 1'b0, a_req_ready, a_req_we = 1'b0;
  logic [31:0] a_req_addr = '0, a_req_wdata = '0, a_rsp_rdata;
  logic        a_rsp_valid, a_rsp_ready = 1'b0, a_rsp_err, a_busy;

  logic        b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0, b_rsp_rdata;
  logic        b_rsp_valid, b_rsp_ready = 1'b1, b_rsp_err, b_busy;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .reset(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .busy(a_busy)
  );

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
  );

  // One full transaction on instance A; entered and left at #1 after an edge in IDLE.
  task automatic a_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 0;
    while (!a_rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    rdata = a_rsp_rdata;
    err   = a_rsp_err;
    n_checks++;
    if (a_rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL xfer_timeout addr=%h: rsp_valid=%b, required 1", addr, a_rsp_valid);
    end
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b required 1", a_req_ready); end
    n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b required 0", a_rsp_valid); end
    n_checks++; if (a_rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h required 0", a_rsp_rdata); end
    n_checks++; if (a_rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b required 0", a_rsp_err); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", a_busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    a_xfer(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL st_latency: got %0d required 3", lat); end
    n_checks++; if (er !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL st_rsp: err=%b rdata=%h required 0/0", er, rd); end
    a_xfer(1'b0, 32'h10, 32'h0, rd, er, lat);
    n_checks++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_rsp: err=%b rdata=%h required 0/deadbeef", er, rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    a_xfer(1'b1, 32'h13, 32'h12345678, rd, er, lat);
    n_checks++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL misaligned_st: err=%b rdata=%h required 1/0", er, rd); end
    a_xfer(1'b0, 32'h1000, 32'h0, rd, er, lat);
    n_checks++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL oor_ld: err=%b rdata=%h required 1/0", er, rd); end
    a_xfer(1'b0, 32'h8000_0010, 32'h0, rd, er, lat);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_high_ld: err=%b required 1", er); end
    a_xfer(1'b0, 32'h10, 32'h0, rd, er, lat);
    n_checks++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_after_err: err=%b rdata=%h required 0/deadbeef", er, rd); end
  endtask

  task automatic test_backpressure();
    int lat;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h10; a_rsp_ready = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    while (!a_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hDEADBEEF || a_req_ready !== 1'b0 || a_busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: valid=%b rdata=%h req_ready=%b busy=%b required 1/deadbeef/0/1",
                           i, a_rsp_valid, a_rsp_rdata, a_req_ready, a_busy);
      end
      @(posedge clk); #1;
    end
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    n_checks++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'd0) begin
      n_fail++; $display("FAIL bp_release: req_ready=%b valid=%b rdata=%h required 1/0/0", a_req_ready, a_rsp_valid, a_rsp_rdata);
    end
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    n_checks++;
    if (a_busy !== 1'b1 || a_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_next_accept: busy=%b req_ready=%b required 1/0", a_busy, a_req_ready);
    end
    lat = 0;
    while (!a_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_checks++; if (a_rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bp_second_ld: got %h required deadbeef", a_rsp_rdata); end
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic er; int lat;
    a_xfer(1'b1, 32'h20, 32'h11112222, rd, er, lat);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_rsp_valid !== 1'b0 || a_busy !== 1'b0 || a_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_wait: valid=%b busy=%b req_ready=%b required 0/0/1", a_rsp_valid, a_busy, a_req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_xfer(1'b0, 32'h20, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h11112222) begin n_fail++; $display("FAIL rst_wait_discard: got %h required 11112222", rd); end
  endtask

  task automatic test_reset_in_resp();
    logic [31:0] rd; logic er; int lat;
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h24; a_req_wdata = 32'h5A5A_A5A5;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 0;
    while (!a_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_rsp_valid !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_resp: valid=%b busy=%b required 0/0", a_rsp_valid, a_busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_xfer(1'b0, 32'h24, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h5A5A_A5A5) begin n_fail++; $display("FAIL rst_resp_keep: got %h required 5a5aa5a5", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int lat;
    a_xfer(1'b1, 32'h0, 32'h01234567, rd, er, lat);
    a_xfer(1'b1, 32'hFFC, 32'hCAFEF00D, rd, er, lat);
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL top_st_err: got %b required 0", er); end
    a_xfer(1'b0, 32'h0, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h01234567) begin n_fail++; $display("FAIL wrap_ld0: got %h required 01234567", rd); end
    a_xfer(1'b0, 32'hFFC, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin n_fail++; $display("FAIL top_ld: rdata=%h err=%b required cafef00d/0", rd, er); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [3];
    logic [31:0] exp;
    data[0] = 32'h1111_0000; data[1] = 32'h2222_0004; data[2] = 32'h3333_0008;
    b_req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_req_we    = (i < 3);
      b_req_addr  = 32'(4 * (i % 3));
      b_req_wdata = data[i % 3];
      exp         = (i < 3) ? 32'd0 : data[i % 3];
      n_checks++; if (b_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b required 1", i, b_req_ready); end
      @(posedge clk); #1;
      n_checks++;
      if (b_rsp_valid !== 1'b0 || b_busy !== 1'b1) begin
        n_fail++; $display("FAIL b2b_access[%0d]: valid=%b busy=%b required 0/1", i, b_rsp_valid, b_busy);
      end
      @(posedge clk); #1;
      n_checks++;
      if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== exp || b_rsp_err !== 1'b0) begin
        n_fail++; $display("FAIL b2b_rsp[%0d]: valid=%b rdata=%h err=%b required 1/%h/0", i, b_rsp_valid, b_rsp_rdata, b_rsp_err, exp);
      end
      @(posedge clk); #1;
    end
    b_req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_reset_in_wait();
    test_reset_in_resp();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
